// File: rtl/fixed_point_mult_pipe.sv
// fixed_point_mult_pipe
// Multi-lane signed fixed-point multiplier with a valid/ready pipeline.
// Each lane forms A*B and aligns it to the result format by an arithmetic
// right shift. Rounding is either floor or half-up. Overflow is either
// clamped or wrapped, and it is reported per lane.
// All lanes share one handshake. The whole pipeline advances only when
// the output register is empty or is being consumed.
//
// Ports
//   clk_in          clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   flush_in        synchronous flush of all in-flight sets and of the sticky flag
//   in_valid        operand set present on a_in/b_in
//   in_ready        operand set is accepted this cycle
//   a_in, b_in      packed signed operands, lane i at [i*W +: W]
//   out_valid       p_out/ovf_out hold a result
//   out_ready       downstream consumes the result
//   p_out           packed signed results
//   ovf_out         per-lane overflow, zero unless out_valid
//   ovf_sticky_out  OR of all consumed ovf bits since reset/flush
module fixed_point_mult_pipe #(
  parameter int LANES       = 1,
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int P_WIDTH     = 16,
  parameter int P_FRAC_BITS = 14,
  parameter int LATENCY     = 2,
  parameter int ROUND       = 0,
  parameter int SATURATE    = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*A_WIDTH-1:0]   a_in,
  input  logic [LANES*B_WIDTH-1:0]   b_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*P_WIDTH-1:0]   p_out,
  output logic [LANES-1:0]           ovf_out,
  output logic                       ovf_sticky_out
);

  localparam int SHIFT    = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  // The working width holds the full product plus the rounding carry. It
  // also holds the result bounds when P_WIDTH is wider than the product.
  localparam int EW = A_WIDTH + B_WIDTH + 1;
  localparam int W  = ((EW > P_WIDTH) ? EW : P_WIDTH) + 1;

  localparam logic signed [W-1:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? (W'(1) << SHIFT_M1) : '0;
  localparam logic signed [W-1:0] P_MAX =
    {{(W-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] P_MIN =
    {{(W-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

  if (SHIFT < 0 || LATENCY < 2 || LATENCY > 8) begin : g_bad_cfg
    $error("fixed_point_mult_pipe: illegal SHIFT or LATENCY");
  end

  // Returns {ovf, p} for one lane.
  function automatic logic [P_WIDTH:0] lane_mul(input logic [A_WIDTH-1:0] a,
                                                input logic [B_WIDTH-1:0] b);
    logic signed [W-1:0]  aw;
    logic signed [W-1:0]  bw;
    logic signed [W-1:0]  sw;
    logic                 ovf;
    logic [P_WIDTH-1:0]   p;
    aw  = {{(W-A_WIDTH){a[A_WIDTH-1]}}, a};
    bw  = {{(W-B_WIDTH){b[B_WIDTH-1]}}, b};
    sw  = (aw * bw + RND_ADD) >>> SHIFT;
    ovf = (sw > P_MAX) || (sw < P_MIN);
    if (ovf && SATURATE != 0) p = sw[W-1] ? P_MIN[P_WIDTH-1:0] : P_MAX[P_WIDTH-1:0];
    else                      p = sw[P_WIDTH-1:0];
    return {ovf, p};
  endfunction

  // Stage 0 registers the operands. Stage 1 registers the lane results.
  // Stages 2..LATENCY only delay them. Stage LATENCY drives the outputs,
  // so a set captured on edge N is presented after edge N+LATENCY.
  logic [LATENCY:0]               vld;
  logic [LANES*A_WIDTH-1:0]       s0_a;
  logic [LANES*B_WIDTH-1:0]       s0_b;
  logic [LANES*P_WIDTH-1:0]       pd [1:LATENCY];
  logic [LANES-1:0]               ov [1:LATENCY];
  logic [LANES*P_WIDTH-1:0]       calc_p;
  logic [LANES-1:0]               calc_ovf;
  logic                           advance;
  logic                           sticky;

  always_comb begin
    calc_p   = '0;
    calc_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      {calc_ovf[i], calc_p[i*P_WIDTH +: P_WIDTH]} =
        lane_mul(s0_a[i*A_WIDTH +: A_WIDTH], s0_b[i*B_WIDTH +: B_WIDTH]);
    end
  end

  assign out_valid = vld[LATENCY];
  assign advance   = !out_valid || out_ready;
  // Gating by rst_n_in keeps in_ready low while reset is held.
  assign in_ready  = rst_n_in && advance && !flush_in;
  assign p_out     = pd[LATENCY];
  assign ovf_out   = out_valid ? ov[LATENCY] : '0;
  assign ovf_sticky_out = sticky;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld  <= '0;
      s0_a <= '0;
      s0_b <= '0;
      for (int i = 1; i <= LATENCY; i++) begin
        pd[i] <= '0;
        ov[i] <= '0;
      end
    end else if (flush_in) begin
      vld <= '0;
    end else if (advance) begin
      // in_ready equals advance on this branch, so in_valid alone marks a transfer.
      vld   <= {vld[LATENCY-1:0], in_valid};
      s0_a  <= a_in;
      s0_b  <= b_in;
      pd[1] <= calc_p;
      ov[1] <= calc_ovf;
      for (int i = 2; i <= LATENCY; i++) begin
        pd[i] <= pd[i-1];
        ov[i] <= ov[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                                 sticky <= 1'b0;
    else if (flush_in)                             sticky <= 1'b0;
    else if (out_valid && out_ready && |ovf_out)   sticky <= 1'b1;
  end

endmodule

// File: tb/tb_fixed_point_mult_pipe.sv
module tb_fixed_point_mult_pipe;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  ovf;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk_in;
  logic        rst_n;
  logic        x_valid, x_flush, x_oready;
  logic [15:0] x_a, x_b;
  logic        x_ir0, x_ov0, x_ovf0, x_st0;
  logic        x_ir1, x_ov1, x_ovf1, x_st1;
  logic [15:0] x_p0, x_p1;
  logic        y_valid, y_flush, y_oready;
  logic [63:0] y_a, y_b, y_p;
  logic        y_ir, y_ov, y_st;
  logic [3:0]  y_ovf;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        sb2[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  bit          lat_en = 1;
  int          stall_from = -100;
  int          stall_to = -100;
  bit          prev_stall[3];
  logic [63:0] prev_p[3];
  logic [3:0]  prev_ovf[3];

  // u0: defaults. u1: round half up, wrap. u2: 4 lanes, latency 5.
  fixed_point_mult_pipe u0 (
    .clk_in(clk_in), .rst_n_in(rst_n), .flush_in(x_flush), .in_valid(x_valid),
    .in_ready(x_ir0), .a_in(x_a), .b_in(x_b), .out_valid(x_ov0), .out_ready(x_oready),
    .p_out(x_p0), .ovf_out(x_ovf0), .ovf_sticky_out(x_st0));

  fixed_point_mult_pipe #(.ROUND(1), .SATURATE(0)) u1 (
    .clk_in(clk_in), .rst_n_in(rst_n), .flush_in(x_flush), .in_valid(x_valid),
    .in_ready(x_ir1), .a_in(x_a), .b_in(x_b), .out_valid(x_ov1), .out_ready(x_oready),
    .p_out(x_p1), .ovf_out(x_ovf1), .ovf_sticky_out(x_st1));

  fixed_point_mult_pipe #(.LANES(4), .LATENCY(5)) u2 (
    .clk_in(clk_in), .rst_n_in(rst_n), .flush_in(y_flush), .in_valid(y_valid),
    .in_ready(y_ir), .a_in(y_a), .b_in(y_b), .out_valid(y_ov), .out_ready(y_oready),
    .p_out(y_p), .ovf_out(y_ovf), .ovf_sticky_out(y_st));

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  // Q2.14 x Q2.14 -> Q2.14 reference, returns {ovf, p}.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit rnd, input bit sat);
    longint      pr;
    logic        ovf;
    logic [15:0] p;
    pr = longint'($signed(a)) * longint'($signed(b));
    if (rnd) pr = pr + 8192;
    pr  = pr >>> 14;
    ovf = (pr > 32767) || (pr < -32768);
    if (ovf && sat) p = (pr > 0) ? 16'h7FFF : 16'h8000;
    else            p = pr[15:0];
    return {ovf, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic ov, input logic ordy, input logic ir,
                     input logic [63:0] p, input logic [3:0] ovf, input int lat);
    exp_t e;
    int   sz;
    if (ov && !ordy) chk($sformatf("in_ready_stall%0d", k), {63'b0, ir}, 64'd0);
    if (ov && prev_stall[k]) begin
      chk($sformatf("p_stable%0d", k), p, prev_p[k]);
      chk($sformatf("ovf_stable%0d", k), {60'b0, ovf}, {60'b0, prev_ovf[k]});
    end
    prev_stall[k] = ov && !ordy;
    prev_p[k]     = p;
    prev_ovf[k]   = ovf;
    if (ov && ordy) begin
      sz = (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
      if (sz == 0) begin
        chk($sformatf("unexpected_out%0d", k), {63'b0, ov}, 64'd0);
      end else begin
        case (k)
          0:       e = sb0.pop_front();
          1:       e = sb1.pop_front();
          default: e = sb2.pop_front();
        endcase
        chk($sformatf("p%0d", k), p, e.p);
        chk($sformatf("ovf%0d", k), {60'b0, ovf}, {60'b0, e.ovf});
        if (e.lat) chk($sformatf("latency%0d", k), 64'(cyc - e.acc), 64'(lat));
      end
    end
  endtask

  always @(negedge clk_in) begin
    #4;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    end else begin
      mon(0, x_ov0, x_oready, x_ir0, {48'b0, x_p0}, {3'b0, x_ovf0}, 2);
      mon(1, x_ov1, x_oready, x_ir1, {48'b0, x_p1}, {3'b0, x_ovf1}, 2);
      mon(2, y_ov, y_oready, y_ir, y_p, y_ovf, 5);
    end
  end

  task automatic x_cycle();
    @(negedge clk_in);
    x_oready = !(cyc >= stall_from && cyc <= stall_to);
  endtask

  task automatic y_cycle();
    @(negedge clk_in);
    y_oready = 1'b1;
  endtask

  task automatic push_x();
    exp_t        e;
    logic [16:0] r;
    r = ref_mul(x_a, x_b, 1'b0, 1'b1);
    e.p = {48'b0, r[15:0]}; e.ovf = {3'b0, r[16]}; e.acc = cyc + 1; e.lat = lat_en;
    sb0.push_back(e);
    r = ref_mul(x_a, x_b, 1'b1, 1'b0);
    e.p = {48'b0, r[15:0]}; e.ovf = {3'b0, r[16]};
    sb1.push_back(e);
  endtask

  task automatic send_x(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    x_cycle();
    x_valid = 1'b1; x_a = a; x_b = b;
    #3;
    while (!(x_ir0 && x_ir1) && n < 50) begin
      x_cycle();
      n++;
      #3;
    end
    if (n >= 50) chk("send_timeout", {63'b0, x_ir0}, 64'd1);
    else         push_x();
  endtask

  task automatic idle_x(input int n);
    repeat (n) begin
      x_cycle();
      x_valid = 1'b0;
    end
  endtask

  task automatic drain_x();
    int n = 0;
    do begin
      x_cycle();
      x_valid = 1'b0;
      n++;
    end while ((sb0.size() + sb1.size()) != 0 && n < 100);
    if (n >= 100) chk("drain_timeout_x", 64'(sb0.size() + sb1.size()), 64'd0);
  endtask

  task automatic send_y(input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [16:0] r;
    int          n = 0;
    y_cycle();
    y_valid = 1'b1; y_a = a; y_b = b;
    #3;
    while (!y_ir && n < 50) begin
      y_cycle();
      n++;
      #3;
    end
    if (n >= 50) begin
      chk("send_timeout_y", {63'b0, y_ir}, 64'd1);
    end else begin
      e.p = '0; e.ovf = '0;
      for (int l = 0; l < 4; l++) begin
        r = ref_mul(a[l*16 +: 16], b[l*16 +: 16], 1'b0, 1'b1);
        e.p[l*16 +: 16] = r[15:0];
        e.ovf[l] = r[16];
      end
      e.acc = cyc + 1; e.lat = 1'b1;
      sb2.push_back(e);
    end
  endtask

  task automatic drain_y();
    int n = 0;
    do begin
      y_cycle();
      y_valid = 1'b0;
      n++;
    end while (sb2.size() != 0 && n < 100);
    if (n >= 100) chk("drain_timeout_y", 64'(sb2.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b1;
    x_valid = 0; x_flush = 0; x_oready = 1; x_a = 0; x_b = 0;
    y_valid = 0; y_flush = 0; y_oready = 1; y_a = 0; y_b = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'b0, x_ov0}, 64'd0);
    chk("rst_in_ready", {63'b0, x_ir0}, 64'd0);
    chk("rst_p", {48'b0, x_p0}, 64'd0);
    chk("rst_sticky", {63'b0, x_st0}, 64'd0);
    chk("rst_y_out_valid", {63'b0, y_ov}, 64'd0);
    chk("rst_y_in_ready", {63'b0, y_ir}, 64'd0);
    chk("rst_y_p", y_p, 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;

    // basic values, rounding, back-to-back throughput
    t0 = cyc;
    send_x(16'd8192, 16'd8192);
    send_x(16'd1, 16'd8192);
    send_x(16'hFFFF, 16'd8192);
    chk("back_to_back", 64'(cyc - t0), 64'd3);
    drain_x();
    chk("sticky_clean0", {63'b0, x_st0}, 64'd0);
    chk("sticky_clean1", {63'b0, x_st1}, 64'd0);

    // overflow: saturate and wrap
    send_x(16'h7FFF, 16'h7FFF);
    drain_x();
    chk("sticky_set0", {63'b0, x_st0}, 64'd1);
    chk("sticky_set1", {63'b0, x_st1}, 64'd1);
    send_x(16'h8000, 16'h8000);
    send_x(16'h8000, 16'h7FFF);
    drain_x();

    // ten-set stream with out_ready low for stream cycles 3-5
    lat_en = 0;
    stall_from = cyc + 4;
    stall_to   = cyc + 6;
    for (int i = 0; i < 10; i++) send_x(16'(i*1500 - 6000), 16'(2000 + i*900));
    drain_x();
    lat_en = 1;
    stall_from = -100;
    stall_to   = -100;

    // flush with two sets in flight and a set presented during the flush
    send_x(16'h7FFF, 16'h7FFF);
    send_x(16'h7FFF, 16'h7FFF);
    x_cycle();
    x_flush = 1'b1; x_valid = 1'b1; x_a = 16'd8192; x_b = 16'd8192;
    #3;
    chk("in_ready_flush", {63'b0, x_ir0}, 64'd0);
    x_cycle();
    x_flush = 1'b0; x_valid = 1'b0;
    sb0.delete(); sb1.delete();
    #1;
    chk("sticky_flush0", {63'b0, x_st0}, 64'd0);
    chk("sticky_flush1", {63'b0, x_st1}, 64'd0);
    idle_x(4);
    chk("flush_quiet", {63'b0, x_ov0}, 64'd0);
    chk("sticky_after_flush", {63'b0, x_st0}, 64'd0);
    send_x(16'd8192, 16'd16384);
    drain_x();

    // reset with two sets in flight
    send_x(16'h8000, 16'h8000);
    drain_x();
    send_x(16'h7FFF, 16'h7FFF);
    send_x(16'h7FFF, 16'h7FFF);
    x_cycle();
    x_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, x_ov0}, 64'd0);
    chk("midrst_in_ready", {63'b0, x_ir0}, 64'd0);
    chk("midrst_p", {48'b0, x_p0}, 64'd0);
    chk("midrst_sticky", {63'b0, x_st0}, 64'd0);
    sb0.delete(); sb1.delete();
    x_cycle();
    rst_n = 1'b1;
    x_valid = 1'b1; x_a = 16'hF000; x_b = 16'h2000;
    #3;
    chk("in_ready_after_rst", {63'b0, x_ir0}, 64'd1);
    push_x();
    drain_x();
    chk("sticky_after_rst", {63'b0, x_st0}, 64'd0);

    // four lanes, latency 5, lane 2 overflowing
    chk("y_sticky_clean", {63'b0, y_st}, 64'd0);
    send_y({16'd100, 16'h7FFF, 16'hE000, 16'h2000},
           {16'hFED4, 16'h7FFF, 16'h2000, 16'h2000});
    drain_y();
    chk("y_sticky_set", {63'b0, y_st}, 64'd1);
    send_y({16'h0100, 16'h8000, 16'h4000, 16'hC000},
           {16'h0100, 16'h7FFF, 16'h1000, 16'h4000});
    send_y({16'h1234, 16'h0000, 16'hFFFF, 16'h7FFF},
           {16'h4321, 16'h7FFF, 16'hFFFF, 16'h0001});
    drain_y();

    chk("sb_leftover", 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
